// File: rtl/user_module_serial_tx.sv
// Framed serial transmitter: start, 5 data bits LSB-first, parity, stop.
// io_in = {data[4:0], valid, rst_n, clk}; io_out = {overrun, slot[2:0], done, ready, busy, txd}.
module user_module_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [4:0] data;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign valid = io_in[2];
    assign data  = io_in[7:3];

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_q;
    logic [4:0] shift_q;
    logic       par_q;
    logic [4:0] hold_q;
    logic       hold_full_q;
    logic       txd_q;
    logic       busy_q;
    logic       done_q;
    logic [2:0] slot_q;
    logic       overrun_q;

    logic       ready;
    logic       accept;
    logic       last;
    logic       stop_end;
    logic       load_new;
    logic       start_d;
    logic       to_hold;
    logic [4:0] word;

    assign ready    = ~hold_full_q;
    assign accept   = valid & ready;
    assign last     = (cnt_q == LAST);
    assign stop_end = (state_q == STOP) && last;
    // A word offered as STOP ends with nothing held starts the next frame at once.
    assign load_new = accept && ((state_q == IDLE) || stop_end);
    assign start_d  = load_new || (stop_end && hold_full_q);
    assign to_hold  = accept && !load_new;
    // load_new only happens with hold empty, so the held word wins when present.
    assign word     = hold_full_q ? hold_q : data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            slot_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            done_q <= stop_end;
            if (valid && !ready) begin
                overrun_q <= 1'b1;
            end
            if (to_hold) begin
                hold_q      <= data;
                hold_full_q <= 1'b1;
            end
            if (stop_end && hold_full_q) begin
                hold_full_q <= 1'b0;
            end
            if (start_d) begin
                shift_q <= word;
                par_q   <= (^word) ^ PARITY_ODD;
                state_q <= START;
                cnt_q   <= '0;
                bit_q   <= '0;
                txd_q   <= 1'b0;
                busy_q  <= 1'b1;
                slot_q  <= 3'd0;
            end else if (state_q != IDLE) begin
                if (!last) begin
                    cnt_q <= cnt_q + 8'd1;
                end else begin
                    cnt_q <= '0;
                    unique case (state_q)
                        START: begin
                            state_q <= DATA;
                            txd_q   <= shift_q[0];
                            slot_q  <= 3'd1;
                        end
                        DATA: begin
                            if (bit_q == 3'd4) begin
                                state_q <= PARITY;
                                txd_q   <= par_q;
                                slot_q  <= 3'd6;
                            end else begin
                                shift_q <= shift_q >> 1;
                                bit_q   <= bit_q + 3'd1;
                                txd_q   <= shift_q[1];
                                slot_q  <= slot_q + 3'd1;
                            end
                        end
                        PARITY: begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                            slot_q  <= 3'd7;
                        end
                        IDLE, STOP: begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            slot_q  <= 3'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign io_out = {overrun_q, slot_q, done_q, ready, busy_q, txd_q};

endmodule

// File: tb/tb_user_module_serial_tx.sv
// Directed bench for user_module_serial_tx: one instance at 4 clocks/bit
// with even parity, one at 1 clock/bit with odd parity.
module tb_user_module_serial_tx;

    logic       clk;
    logic       rst_n;
    logic       v4;
    logic       v1;
    logic [4:0] d4;
    logic [4:0] d1;
    logic [7:0] o4;
    logic [7:0] o1;
    int         checks;
    int         errors;

    user_module_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u4 (
        .io_in ({d4, v4, rst_n, clk}),
        .io_out(o4)
    );

    user_module_serial_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) u1 (
        .io_in ({d1, v1, rst_n, clk}),
        .io_out(o1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Two frames back to back, optionally with an overrun attempt while hold is full.
    task automatic b2b(input bit inj);
        logic [7:0] s [2];
        logic [7:0] e;
        int         f;
        int         sl;
        s[0] = 8'b1100_0010;
        s[1] = 8'b1111_1110;
        v4 = 1'b1;
        d4 = 5'b00001;
        step();
        v4 = 1'b0;
        d4 = 5'b10101;
        for (int i = 0; i <= 64; i++) begin
            f  = i / 32;
            sl = (i % 32) / 4;
            if (i == 64) begin
                e = {inj, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
            end else begin
                e = {inj && (i >= 11), 3'(sl), i == 32,
                     !((i >= 6) && (i < 32)), 1'b1, s[f][sl]};
            end
            chk($sformatf("b2b%0d_c%0d", inj, i), o4, e);
            if (i == 5) begin
                v4 = 1'b1;
                d4 = 5'b11111;
            end
            if (i == 6) begin
                v4 = 1'b0;
                d4 = 5'b00000;
            end
            if (inj && (i == 10)) begin
                v4 = 1'b1;
                d4 = 5'b01010;
            end
            if (i == 11) begin
                v4 = 1'b0;
            end
            if (i < 64) begin
                step();
            end
        end
    endtask

    initial begin
        logic [7:0] seq2;
        logic [7:0] seq6;
        logic [7:0] e;
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        v4     = 1'b0;
        v1     = 1'b0;
        d4     = '0;
        d1     = '0;
        seq2   = 8'b1110_1100;
        seq6   = 8'b1100_0000;

        // Reset and idle
        step();
        step();
        chk("rst4", o4, 8'h05);
        chk("rst1", o1, 8'h05);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle4_%0d", i), o4, 8'h05);
            chk($sformatf("idle1_%0d", i), o1, 8'h05);
        end

        // Single frame, data sampled only at accept
        v4 = 1'b1;
        d4 = 5'b10110;
        step();
        v4 = 1'b0;
        d4 = 5'b01001;
        for (int i = 0; i < 32; i++) begin
            e = {1'b0, 3'(i / 4), 1'b0, 1'b1, 1'b1, seq2[i / 4]};
            chk($sformatf("single_c%0d", i), o4, e);
            step();
        end
        chk("single_done", o4, 8'h0D);
        step();
        chk("single_idle", o4, 8'h05);

        // Back to back, then again with an overrun attempt
        step();
        b2b(1'b0);
        step();
        chk("b2b_idle", o4, 8'h05);
        b2b(1'b1);
        step();
        chk("ovr_sticky", o4, 8'h85);
        step();
        chk("ovr_sticky2", o4, 8'h85);

        // Reset mid-frame with a word waiting in hold
        v4 = 1'b1;
        d4 = 5'b10110;
        step();
        v4 = 1'b0;
        step();
        step();
        v4 = 1'b1;
        d4 = 5'b00011;
        step();
        v4 = 1'b0;
        chk("mid_holdfull", o4, 8'b1000_0010);
        for (int i = 3; i < 13; i++) begin
            step();
        end
        chk("mid_slot3", o4, 8'b1011_0011);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst", o4, 8'h05);
        for (int i = 0; i < 40; i++) begin
            step();
            chk($sformatf("mid_after%0d", i), o4, 8'h05);
        end

        // Fast rate, odd parity, accept on the edge that ends STOP
        v1 = 1'b1;
        d1 = 5'b00000;
        step();
        v1 = 1'b0;
        d1 = 5'b11011;
        for (int i = 0; i <= 16; i++) begin
            if (i == 16) begin
                e = 8'h0D;
            end else begin
                e = {1'b0, 3'(i % 8), i == 8, 1'b1, 1'b1, seq6[i % 8]};
            end
            chk($sformatf("fast_c%0d", i), o1, e);
            if (i == 7) begin
                v1 = 1'b1;
                d1 = 5'b00000;
            end
            if (i == 8) begin
                v1 = 1'b0;
                d1 = 5'b11011;
            end
            if (i < 16) begin
                step();
            end
        end
        step();
        chk("fast_idle", o1, 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
